// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle for mem_responder; err exists only with MEMRESP_BOUNDS_EN.
// Requests are accepted only while idle, and a request raised while busy is not queued.
`ifndef WORDSIZE
`define WORDSIZE 16
`endif

interface mem_responder_if #(
  parameter int n = `WORDSIZE
);
  logic         req;
  logic         we;
  logic [n-1:0] addr;
  logic [n-1:0] wdata;
  logic [n-1:0] rdata;
  logic         ack;
  logic         busy;
`ifdef MEMRESP_BOUNDS_EN
  logic         err;
`endif

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, busy
`ifdef MEMRESP_BOUNDS_EN
    , input err
`endif
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, busy
`ifdef MEMRESP_BOUNDS_EN
    , output err
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory: ack arrives LATENCY cycles after acceptance, and requests made while busy are dropped.
// MEMRESP_BOUNDS_EN flags out-of-range addresses on err and suppresses those accesses.
`ifndef WORDSIZE
`define WORDSIZE 16
`endif

module mem_responder #(
  parameter int n       = `WORDSIZE,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [3:0]     r_cnt;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [n-1:0]   r_wdata;
  logic [n-1:0]   r_rdata;
  logic           r_oob;
  logic [n-1:0]   r_mem [DEPTH];

  logic           w_accept;
  logic           w_enter_ack;
  logic           w_we;
  logic [AW-1:0]  w_idx;
  logic [n-1:0]   w_wdata;
  logic           w_oob;
  logic           w_addr_oob;

  assign w_accept = (r_state == ST_IDLE) && bus.req;

  // With LATENCY=1 the ACK entry coincides with acceptance, so the live inputs are used.
  assign w_we    = (r_state == ST_IDLE) ? bus.we : r_we;
  assign w_idx   = (r_state == ST_IDLE) ? bus.addr[AW-1:0] : r_addr;
  assign w_wdata = (r_state == ST_IDLE) ? bus.wdata : r_wdata;
  assign w_oob   = (r_state == ST_IDLE) ? w_addr_oob : r_oob;

`ifdef MEMRESP_BOUNDS_EN
  assign w_addr_oob = (bus.addr >> AW) != '0;
`else
  assign w_addr_oob = 1'b0;
`endif

  assign w_enter_ack = (w_next == ST_ACK) && (r_state != ST_ACK) && !reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    bus.ack  = 1'b0;
    bus.busy = 1'b1;
    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (bus.req) w_next = (LATENCY == 1) ? ST_ACK : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_ACK;
      end
      ST_ACK: begin
        bus.ack = 1'b1;
        w_next  = ST_IDLE;
      end
      default: begin
        w_next   = ST_IDLE;
        bus.busy = 1'b0;
      end
    endcase
  end

  assign bus.rdata = r_rdata;
`ifdef MEMRESP_BOUNDS_EN
  assign bus.err = (r_state == ST_ACK) && r_oob;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_oob   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_we    <= bus.we;
        r_addr  <= bus.addr[AW-1:0];
        r_wdata <= bus.wdata;
        r_oob   <= w_addr_oob;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_ack && !w_we) begin
        r_rdata <= w_oob ? '0 : r_mem[w_idx];
      end
    end
  end

  // Storage has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_enter_ack && w_we && !w_oob) r_mem[w_idx] <= w_wdata;
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected read data, latency/busy/ack checks.
// Reference memory model in the bench tracks completed writes.
module tb_mem_responder;
  localparam int LAT = 2;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] model [256];
  logic [15:0] sb_q [$];
  logic [15:0] last_rd;

  mem_responder_if #(.n(16)) bus ();

  mem_responder #(.n(16), .DEPTH(256), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_oob(input logic [15:0] a);
`ifdef MEMRESP_BOUNDS_EN
    return a >= 16'd256;
`else
    return 1'b0;
`endif
  endfunction

  // Drive a request at an idle cycle; the following edge accepts it.
  task automatic start(input logic w, input logic [15:0] a, input logic [15:0] d, input bit hold);
    bus.req   = 1'b1;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    if (!w) sb_q.push_back(is_oob(a) ? 16'h0000 : model[a[7:0]]);
    tick();
    if (!hold) bus.req = 1'b0;
  endtask

  // Called in the first cycle after the acceptance edge.
  task automatic finish(input string tag, input logic w, input logic [15:0] a, input logic [15:0] d);
    int lat;
    logic [15:0] exp;
    lat = 1;
    while (bus.ack !== 1'b1 && lat < 20) begin
      check({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busy_ack"}, 32'(bus.busy), 32'd1);
    if (!w) begin
      check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check({tag, "_rdata"}, 32'(bus.rdata), 32'(exp));
        last_rd = exp;
      end
    end else begin
      check({tag, "_rdata_hold"}, 32'(bus.rdata), 32'(last_rd));
      if (!is_oob(a)) model[a[7:0]] = d;
    end
`ifdef MEMRESP_BOUNDS_EN
    check({tag, "_err"}, 32'(bus.err), 32'(is_oob(a)));
`endif
    tick();
    check({tag, "_ack_after"}, 32'(bus.ack), 32'd0);
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    last_rd   = 16'h0000;
    reset     = 1'b1;
    bus.req   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 16'h0000;
    bus.wdata = 16'h0000;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_rdata", 32'(bus.rdata), 32'h0000);
`ifdef MEMRESP_BOUNDS_EN
    check("reset_err", 32'(bus.err), 32'd0);
`endif

    // Basic write then read.
    start(1'b1, 16'h0005, 16'hBEEF, 1'b0);
    finish("wr5", 1'b1, 16'h0005, 16'hBEEF);
    start(1'b0, 16'h0005, 16'h0000, 1'b0);
    finish("rd5", 1'b0, 16'h0005, 16'h0000);
    check("rd5_const", 32'(bus.rdata), 32'h0000BEEF);

    // Request held through WAIT/ACK with changed inputs is only taken at the next idle.
    start(1'b1, 16'h0007, 16'h1111, 1'b0);
    finish("wr7", 1'b1, 16'h0007, 16'h1111);
    start(1'b0, 16'h0007, 16'h0000, 1'b1);
    bus.we    = 1'b1;
    bus.wdata = 16'h2222;
    finish("rd7_held", 1'b0, 16'h0007, 16'h0000);
    check("rd7_held_const", 32'(bus.rdata), 32'h00001111);
    tick();
    check("held_accept_busy", 32'(bus.busy), 32'd1);
    bus.req = 1'b0;
    finish("wr7_held", 1'b1, 16'h0007, 16'h2222);
    start(1'b0, 16'h0007, 16'h0000, 1'b0);
    finish("rd7_new", 1'b0, 16'h0007, 16'h0000);
    check("rd7_new_const", 32'(bus.rdata), 32'h00002222);

    // Reset during WAIT aborts a pending write.
    start(1'b1, 16'h0003, 16'h3333, 1'b0);
    finish("wr3", 1'b1, 16'h0003, 16'h3333);
    start(1'b1, 16'h0003, 16'h1234, 1'b0);
    check("abort_wait_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ack", 32'(bus.ack), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'h0000);
    last_rd = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_ack", 32'(bus.ack), 32'd0);
    end
    start(1'b0, 16'h0003, 16'h0000, 1'b0);
    finish("rd3", 1'b0, 16'h0003, 16'h0000);
    check("rd3_const", 32'(bus.rdata), 32'h00003333);

`ifndef MEMRESP_BOUNDS_EN
    // Upper address bits are ignored.
    start(1'b1, 16'h0105, 16'h00AA, 1'b0);
    finish("wr105", 1'b1, 16'h0105, 16'h00AA);
    start(1'b0, 16'h0005, 16'h0000, 1'b0);
    finish("rd5_wrap", 1'b0, 16'h0005, 16'h0000);
    check("rd5_wrap_const", 32'(bus.rdata), 32'h000000AA);
`else
    // Out-of-range accesses flag err and do not touch storage.
    start(1'b1, 16'h0105, 16'h00AA, 1'b0);
    finish("wr105_oob", 1'b1, 16'h0105, 16'h00AA);
    start(1'b0, 16'h0005, 16'h0000, 1'b0);
    finish("rd5_kept", 1'b0, 16'h0005, 16'h0000);
    check("rd5_kept_const", 32'(bus.rdata), 32'h0000BEEF);
    start(1'b0, 16'h0105, 16'h0000, 1'b0);
    finish("rd105_oob", 1'b0, 16'h0105, 16'h0000);
    check("rd105_oob_const", 32'(bus.rdata), 32'h00000000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
